// File: rtl/zx_cart_mapper_if.sv
// Z80-side bus bundle for the cartridge mapper: CPU control/address/data in,
// cartridge ROM select lines and status out.
interface zx_cart_mapper_if;
  logic       iorq_n;
  logic       wr_n;
  logic       rd_n;
  logic       mreq_n;
  logic       A7;
  logic       A13;
  logic       A14;
  logic       A15;
  logic [7:0] D;
  logic       ZX_ROM_blk;
  logic       CR_ROM_oe_n;
  logic [5:0] CR_ROM_A;
  logic       locked;
  logic       busy;

  modport master (
    output iorq_n, wr_n, rd_n, mreq_n, A7, A13, A14, A15, D,
    input  ZX_ROM_blk, CR_ROM_oe_n, CR_ROM_A, locked, busy
  );

  modport slave (
    input  iorq_n, wr_n, rd_n, mreq_n, A7, A13, A14, A15, D,
    output ZX_ROM_blk, CR_ROM_oe_n, CR_ROM_A, locked, busy
  );
endinterface

// File: rtl/zx_cart_mapper.sv
// ZX Spectrum cartridge bank mapper: port 0x7F write register with deferred apply.
// Optional ZX_CART_AUTOINC_EN: an I/O read of port 0x7F increments the bank.
module zx_cart_mapper #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [5:0] RESET_BANK  = 6'd0
) (
  input  logic            clk,
  input  logic            reset_n,
  zx_cart_mapper_if.slave bus
);

`ifdef ZX_CART_AUTOINC_EN
  localparam int NCTL = 8;
`else
  localparam int NCTL = 7;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_END,
    ST_APPLY,
    ST_LOCKED
  } state_t;

  logic [NCTL-1:0] w_raw;
  logic [NCTL-1:0] r_sync [SYNC_STAGES];
  logic [NCTL-1:0] w_sync;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_pend;
  logic [7:0] w_pend_next;
  logic [5:0] r_bank;
  logic       r_cart_off;
  logic       r_lock;
  logic       r_wr_cond;
  logic       w_wr_cond;
  logic       w_wr_strobe;
  logic       w_rd_strobe;
  logic       w_lower_busy;
  logic       w_lower_raw;
  logic       w_oe_n;
  logic       w_capture;
  logic       w_apply;

  // Bit map: 0 iorq_n, 1 wr_n, 2 mreq_n, 3 A7, 4 A13, 5 A14, 6 A15, 7 rd_n
`ifdef ZX_CART_AUTOINC_EN
  assign w_raw = {bus.rd_n, bus.A15, bus.A14, bus.A13, bus.A7,
                  bus.mreq_n, bus.wr_n, bus.iorq_n};
`else
  assign w_raw = {bus.A15, bus.A14, bus.A13, bus.A7,
                  bus.mreq_n, bus.wr_n, bus.iorq_n};
`endif

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_sync[gi] <= '1;
        end else if (gi == 0) begin
          r_sync[gi] <= w_raw;
        end else begin
          r_sync[gi] <= r_sync[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign w_sync       = r_sync[SYNC_STAGES-1];
  assign w_wr_cond    = w_sync[0] | w_sync[1] | w_sync[3];
  assign w_wr_strobe  = r_wr_cond & ~w_wr_cond & ~r_lock;
  assign w_lower_busy = ~w_sync[2] & ~w_sync[4] & ~w_sync[5] & ~w_sync[6];

`ifdef ZX_CART_AUTOINC_EN
  logic r_rd_cond;
  logic w_rd_cond;

  assign w_rd_cond   = w_sync[0] | w_sync[7] | w_sync[3];
  assign w_rd_strobe = r_rd_cond & ~w_rd_cond & ~r_lock;
  // A read-triggered update keeps cart_off and bumps the bank, wrapping at 64.
  assign w_pend_next = w_wr_strobe ? bus.D : {1'b0, r_cart_off, r_bank + 6'd1};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_cond <= 1'b1;
    end else begin
      r_rd_cond <= w_rd_cond;
    end
  end
`else
  assign w_rd_strobe = 1'b0;
  assign w_pend_next = bus.D;
`endif

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_apply      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_strobe || w_rd_strobe) begin
          w_capture    = 1'b1;
          w_state_next = ST_WAIT_END;
        end
      end
      ST_WAIT_END: begin
        if (w_sync[0]) begin
          w_state_next = ST_APPLY;
        end
      end
      ST_APPLY: begin
        // Hold the old bank until any lower-ROM access has finished.
        if (!w_lower_busy) begin
          w_apply      = 1'b1;
          w_state_next = r_pend[7] ? ST_LOCKED : ST_IDLE;
        end
      end
      ST_LOCKED: begin
        w_state_next = ST_LOCKED;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_pend     <= 8'd0;
      r_bank     <= RESET_BANK;
      r_cart_off <= 1'b0;
      r_lock     <= 1'b0;
      r_wr_cond  <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_wr_cond <= w_wr_cond;
      if (w_capture) begin
        r_pend <= w_pend_next;
      end
      if (w_apply) begin
        r_bank     <= r_pend[5:0];
        r_cart_off <= r_pend[6];
        r_lock     <= r_pend[7];
      end
    end
  end

  // Output enable stays combinational on the raw bus for ROM access time.
  assign w_lower_raw     = ~bus.A15 & ~bus.A14 & ~bus.A13;
  assign w_oe_n          = ~w_lower_raw | bus.rd_n | bus.mreq_n | r_cart_off;
  assign bus.CR_ROM_oe_n = w_oe_n;
  assign bus.ZX_ROM_blk  = ~w_oe_n;
  assign bus.CR_ROM_A    = r_bank;
  assign bus.locked      = r_lock;
  assign bus.busy        = (r_state == ST_WAIT_END) || (r_state == ST_APPLY);

endmodule

// File: tb/tb_zx_cart_mapper.sv
// Directed bench for zx_cart_mapper: reset, writes, deferred apply, lock,
// mid-wait reset and the optional read-increment.
module tb_zx_cart_mapper;
  localparam int S = 2;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  int   t_busy;
  int   t_apply;
  int   n_busy;

  zx_cart_mapper_if bus ();

  zx_cart_mapper #(
    .SYNC_STAGES(S),
    .RESET_BANK (6'd0)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.iorq_n = 1'b1;
    bus.wr_n   = 1'b1;
    bus.rd_n   = 1'b1;
    bus.mreq_n = 1'b1;
    bus.A7     = 1'b1;
    bus.A13    = 1'b1;
    bus.A14    = 1'b1;
    bus.A15    = 1'b1;
    bus.D      = 8'h00;
  endtask

  task automatic mem_read(input logic a15, input logic a14, input logic a13);
    bus.A15    = a15;
    bus.A14    = a14;
    bus.A13    = a13;
    bus.mreq_n = 1'b0;
    bus.rd_n   = 1'b0;
  endtask

  // Drive one I/O cycle from a negedge (index 0), observe 40 negedges.
  // hold: negedge index at which IORQ releases; mreq_rel: index at which a
  // held memory read is released (0 = none).
  task automatic io_cycle(input logic is_wr, input logic [7:0] d, input logic a7,
                          input int hold, input int mreq_rel, input logic [5:0] exp_bank,
                          output int tb_o, output int ta_o, output int nb_o);
    tb_o = -1;
    ta_o = -1;
    nb_o = 0;
    @(negedge clk);
    bus.D      = d;
    bus.A7     = a7;
    bus.iorq_n = 1'b0;
    if (is_wr) bus.wr_n = 1'b0;
    else       bus.rd_n = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.busy) begin
        nb_o++;
        if (tb_o < 0) tb_o = i;
      end
      if (ta_o < 0 && bus.CR_ROM_A == exp_bank) ta_o = i;
      if (i == hold) begin
        bus.iorq_n = 1'b1;
        if (is_wr) bus.wr_n = 1'b1;
        else       bus.rd_n = 1'b1;
        bus.A7 = 1'b1;
      end
      if (i == mreq_rel) begin
        bus.mreq_n = 1'b1;
        bus.rd_n   = 1'b1;
      end
    end
    $display("io %s d=%02h a7=%0b busy_at=%0d busy_cycles=%0d bank_at=%0d bank=%0d",
             is_wr ? "OUT" : "IN ", d, a7, tb_o, nb_o, ta_o, bus.CR_ROM_A);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus_idle();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state and raw-bus output enable
    chk("rst_bank", bus.CR_ROM_A, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_busy", bus.busy, 0);
    chk("idle_oe_n", bus.CR_ROM_oe_n, 1);
    mem_read(1'b0, 1'b0, 1'b0);
    #1;
    chk("rd0000_oe_n", bus.CR_ROM_oe_n, 0);
    chk("rd0000_blk", bus.ZX_ROM_blk, 1);
    $display("read 0000 oe_n=%0b blk=%0b", bus.CR_ROM_oe_n, bus.ZX_ROM_blk);
    mem_read(1'b0, 1'b1, 1'b0);
    #1;
    chk("rd4000_oe_n", bus.CR_ROM_oe_n, 1);
    chk("rd4000_blk", bus.ZX_ROM_blk, 0);
    $display("read 4000 oe_n=%0b blk=%0b", bus.CR_ROM_oe_n, bus.ZX_ROM_blk);
    bus_idle();

    // OUT (0x7F),0x05 on idle bus: capture at S+1, apply at hold+S+2
    io_cycle(1'b1, 8'h05, 1'b0, 4, 0, 6'd5, t_busy, t_apply, n_busy);
    chk("out05_busy_at", t_busy, S + 1);
    chk("out05_apply_at", t_apply, 4 + S + 2);
    chk("out05_busy_len", n_busy, 4 + 1);
    chk("out05_bank", bus.CR_ROM_A, 5);

    // Port with A7 = 1 is not decoded
    io_cycle(1'b1, 8'h22, 1'b1, 4, 0, 6'h22, t_busy, t_apply, n_busy);
    chk("a7hi_busy_len", n_busy, 0);
    chk("a7hi_bank", bus.CR_ROM_A, 5);

    // OUT 0x0A during a lower-ROM read held 20 clk: apply S+1 after release
    @(negedge clk);
    mem_read(1'b0, 1'b0, 1'b0);
    #1;
    chk("mreq_oe_n", bus.CR_ROM_oe_n, 0);
    io_cycle(1'b1, 8'h0A, 1'b0, 4, 20, 6'h0A, t_busy, t_apply, n_busy);
    chk("mreq_apply_at", t_apply, 20 + S + 1);
    chk("mreq_bank", bus.CR_ROM_A, 10);
    bus_idle();

    // OUT 0xC0: lock + cart_off, bank 0
    io_cycle(1'b1, 8'hC0, 1'b0, 4, 0, 6'd0, t_busy, t_apply, n_busy);
    chk("lock_apply_at", t_apply, 4 + S + 2);
    chk("lock_locked", bus.locked, 1);
    mem_read(1'b0, 1'b0, 1'b0);
    #1;
    chk("lock_rd0000_oe_n", bus.CR_ROM_oe_n, 1);
    chk("lock_rd0000_blk", bus.ZX_ROM_blk, 0);
    bus_idle();
    io_cycle(1'b1, 8'h03, 1'b0, 4, 0, 6'd3, t_busy, t_apply, n_busy);
    chk("lock_out03_busy", n_busy, 0);
    chk("lock_out03_bank", bus.CR_ROM_A, 0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("unlock_locked", bus.locked, 0);
    chk("unlock_bank", bus.CR_ROM_A, 0);
    mem_read(1'b0, 1'b0, 1'b0);
    #1;
    chk("unlock_oe_n", bus.CR_ROM_oe_n, 0);
    $display("reset pulse locked=%0b bank=%0d oe_n=%0b", bus.locked, bus.CR_ROM_A, bus.CR_ROM_oe_n);
    bus_idle();

    // Reset in WAIT_END discards pending 0x11
    io_cycle(1'b1, 8'h05, 1'b0, 4, 0, 6'd5, t_busy, t_apply, n_busy);
    chk("pre_rst_bank", bus.CR_ROM_A, 5);
    @(negedge clk);
    bus.D      = 8'h11;
    bus.A7     = 1'b0;
    bus.iorq_n = 1'b0;
    bus.wr_n   = 1'b0;
    repeat (S + 1) @(negedge clk);
    chk("wait_busy", bus.busy, 1);
    @(negedge clk);
    reset_n = 1'b0;
    bus_idle();
    @(negedge clk);
    reset_n = 1'b1;
    chk("wait_rst_bank", bus.CR_ROM_A, 0);
    chk("wait_rst_busy", bus.busy, 0);
    repeat (12) @(negedge clk);
    chk("wait_rst_late_bank", bus.CR_ROM_A, 0);
    chk("wait_rst_late_busy", bus.busy, 0);
    $display("reset in WAIT_END bank=%0d busy=%0b", bus.CR_ROM_A, bus.busy);

    // Bank 63, then IN (0x7F)
    io_cycle(1'b1, 8'h3F, 1'b0, 4, 0, 6'd63, t_busy, t_apply, n_busy);
    chk("bank63", bus.CR_ROM_A, 63);
`ifdef ZX_CART_AUTOINC_EN
    io_cycle(1'b0, 8'h00, 1'b0, 4, 0, 6'd0, t_busy, t_apply, n_busy);
    chk("in_busy_len", n_busy, 4 + 1);
    chk("in_bank", bus.CR_ROM_A, 0);
`else
    io_cycle(1'b0, 8'h00, 1'b0, 4, 0, 6'd0, t_busy, t_apply, n_busy);
    chk("in_busy_len", n_busy, 0);
    chk("in_bank", bus.CR_ROM_A, 63);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
